// File: rtl/trace_checker.sv
// rtl/trace_checker.sv - golden-trace checker for the core write-back debug interface
//
// Ports:
//   clk, reset                      clock; synchronous active-high reset
//   exp_valid/exp_ready             expected-entry push handshake
//   exp_pc/exp_wnum/exp_wdata       expected commit contents
//   debug_wb_pc/rf_we/rf_wnum/rf_wdata  core write-back trace
//   fifo_count                      expected-entry FIFO occupancy
//   pass_cnt                        matched commits
//   err/underflow                   sticky failure flags
//   err_pc/err_wnum/err_got_wdata/err_exp_wdata  first failing commit

module trace_checker #(
    parameter int FIFO_DEPTH = 16,
    parameter int PTR_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             exp_valid,
    output logic             exp_ready,
    input  logic [31:0]      exp_pc,
    input  logic [4:0]       exp_wnum,
    input  logic [31:0]      exp_wdata,
    input  logic [31:0]      debug_wb_pc,
    input  logic [3:0]       debug_wb_rf_we,
    input  logic [4:0]       debug_wb_rf_wnum,
    input  logic [31:0]      debug_wb_rf_wdata,
    output logic [PTR_W:0]   fifo_count,
    output logic [31:0]      pass_cnt,
    output logic             err,
    output logic             underflow,
    output logic [31:0]      err_pc,
    output logic [4:0]       err_wnum,
    output logic [31:0]      err_got_wdata,
    output logic [31:0]      err_exp_wdata
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic {
        RUN   = 1'b0,
        ERROR = 1'b1
    } state_t;

    state_t state;

    logic [31:0] mem_pc    [FIFO_DEPTH];
    logic [4:0]  mem_wnum  [FIFO_DEPTH];
    logic [31:0] mem_wdata [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic commit;
    logic fifo_empty;
    logic head_match;
    logic do_push;
    logic do_pop;

    // Full is judged on the pre-edge count, so a same-cycle pop never frees a slot for a push.
    assign exp_ready  = !reset && (fifo_count != FULL_COUNT);
    assign commit     = (debug_wb_rf_we != 4'd0) && (debug_wb_rf_wnum != 5'd0);
    assign fifo_empty = (fifo_count == '0);
    assign head_match = (mem_pc[rd_ptr] == debug_wb_pc) &&
                        (mem_wnum[rd_ptr] == debug_wb_rf_wnum) &&
                        (mem_wdata[rd_ptr] == debug_wb_rf_wdata);
    assign do_push    = exp_valid && exp_ready;
    // Only RUN consumes entries; in ERROR the queue just accumulates pushes.
    assign do_pop     = (state == RUN) && commit && !fifo_empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_pc[wr_ptr]    <= exp_pc;
            mem_wnum[wr_ptr]  <= exp_wnum;
            mem_wdata[wr_ptr] <= exp_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= RUN;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            pass_cnt      <= '0;
            err           <= 1'b0;
            underflow     <= 1'b0;
            err_pc        <= '0;
            err_wnum      <= '0;
            err_got_wdata <= '0;
            err_exp_wdata <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (!do_push && do_pop) begin
                fifo_count <= fifo_count - 1'b1;
            end

            case (state)
                RUN: begin
                    if (commit) begin
                        if (fifo_empty) begin
                            underflow     <= 1'b1;
                            err           <= 1'b1;
                            err_pc        <= debug_wb_pc;
                            err_wnum      <= debug_wb_rf_wnum;
                            err_got_wdata <= debug_wb_rf_wdata;
                            err_exp_wdata <= '0;
                            state         <= ERROR;
                        end else if (head_match) begin
                            pass_cnt <= pass_cnt + 32'd1;
                        end else begin
                            err           <= 1'b1;
                            err_pc        <= debug_wb_pc;
                            err_wnum      <= debug_wb_rf_wnum;
                            err_got_wdata <= debug_wb_rf_wdata;
                            err_exp_wdata <= mem_wdata[rd_ptr];
                            state         <= ERROR;
                        end
                    end
                end
                ERROR: begin
                    state <= ERROR;
                end
                default: begin
                    state <= ERROR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trace_checker.sv
// tb/tb_trace_checker.sv - scoreboard bench for trace_checker against a queue-based reference model

module tb_trace_checker;

    localparam int DEPTH = 16;
    localparam int PTR_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             exp_valid;
    logic             exp_ready;
    logic [31:0]      exp_pc;
    logic [4:0]       exp_wnum;
    logic [31:0]      exp_wdata;
    logic [31:0]      debug_wb_pc;
    logic [3:0]       debug_wb_rf_we;
    logic [4:0]       debug_wb_rf_wnum;
    logic [31:0]      debug_wb_rf_wdata;
    logic [PTR_W:0]   fifo_count;
    logic [31:0]      pass_cnt;
    logic             err;
    logic             underflow;
    logic [31:0]      err_pc;
    logic [4:0]       err_wnum;
    logic [31:0]      err_got_wdata;
    logic [31:0]      err_exp_wdata;

    always #5 clk = ~clk;

    trace_checker #(.FIFO_DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .exp_valid         (exp_valid),
        .exp_ready         (exp_ready),
        .exp_pc            (exp_pc),
        .exp_wnum          (exp_wnum),
        .exp_wdata         (exp_wdata),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .fifo_count        (fifo_count),
        .pass_cnt          (pass_cnt),
        .err               (err),
        .underflow         (underflow),
        .err_pc            (err_pc),
        .err_wnum          (err_wnum),
        .err_got_wdata     (err_got_wdata),
        .err_exp_wdata     (err_exp_wdata)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } ent_t;

    typedef struct packed {
        logic        ready;
        logic [4:0]  count;
        logic [31:0] pass;
        logic        err;
        logic        unf;
        logic [31:0] epc;
        logic [4:0]  ewnum;
        logic [31:0] egot;
        logic [31:0] eexp;
    } snap_t;

    // Reference model: expected-entry queue plus checker status
    ent_t        mq[$];
    snap_t       sb[$];
    logic [31:0] m_pass = '0;
    logic        m_err = 1'b0;
    logic        m_unf = 1'b0;
    logic [31:0] m_epc = '0;
    logic [4:0]  m_ewnum = '0;
    logic [31:0] m_egot = '0;
    logic [31:0] m_eexp = '0;

    int checks = 0;
    int errors = 0;
    snap_t mon_s;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: every cycle the DUT presents its status; compare against the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                mon_s = sb.pop_front();
                chk("exp_ready",     32'(exp_ready),     32'(mon_s.ready));
                chk("fifo_count",    32'(fifo_count),    32'(mon_s.count));
                chk("pass_cnt",      pass_cnt,           mon_s.pass);
                chk("err",           32'(err),           32'(mon_s.err));
                chk("underflow",     32'(underflow),     32'(mon_s.unf));
                chk("err_pc",        err_pc,             mon_s.epc);
                chk("err_wnum",      32'(err_wnum),      32'(mon_s.ewnum));
                chk("err_got_wdata", err_got_wdata,      mon_s.egot);
                chk("err_exp_wdata", err_exp_wdata,      mon_s.eexp);
            end
        end
    end

    // One clock cycle: drive inputs, record what must be visible this cycle, then advance the model.
    task automatic step(input logic r, input logic ev, input ent_t e, input logic [3:0] we, input ent_t c);
        snap_t s;
        bit    is_commit;
        bit    room;
        ent_t  h;
        @(posedge clk);
        #1;
        reset             = r;
        exp_valid         = ev;
        exp_pc            = e.pc;
        exp_wnum          = e.wnum;
        exp_wdata         = e.wdata;
        debug_wb_rf_we    = we;
        debug_wb_pc       = c.pc;
        debug_wb_rf_wnum  = c.wnum;
        debug_wb_rf_wdata = c.wdata;

        room    = (mq.size() != DEPTH);
        s.ready = !r && room;
        s.count = 5'(mq.size());
        s.pass  = m_pass;
        s.err   = m_err;
        s.unf   = m_unf;
        s.epc   = m_epc;
        s.ewnum = m_ewnum;
        s.egot  = m_egot;
        s.eexp  = m_eexp;
        sb.push_back(s);

        if (r) begin
            mq.delete();
            m_pass = '0; m_err = 0; m_unf = 0;
            m_epc = '0; m_ewnum = '0; m_egot = '0; m_eexp = '0;
        end else begin
            is_commit = (we != 0) && (c.wnum != 0);
            if (!m_err && is_commit) begin
                if (mq.size() == 0) begin
                    m_unf = 1; m_err = 1;
                    m_epc = c.pc; m_ewnum = c.wnum; m_egot = c.wdata; m_eexp = '0;
                end else begin
                    h = mq.pop_front();
                    if (h == c) begin
                        m_pass = m_pass + 1;
                    end else begin
                        m_err = 1;
                        m_epc = c.pc; m_ewnum = c.wnum; m_egot = c.wdata; m_eexp = h.wdata;
                    end
                end
            end
            if (ev && room) mq.push_back(e);
        end
    endtask

    function automatic ent_t mk(input logic [31:0] pc, input logic [4:0] wn, input logic [31:0] wd);
        ent_t t;
        t.pc = pc; t.wnum = wn; t.wdata = wd;
        return t;
    endfunction

    ent_t none;

    task automatic push(input ent_t e);
        step(0, 1, e, 4'h0, none);
    endtask

    task automatic commit(input logic [3:0] we, input ent_t c);
        step(0, 0, none, we, c);
    endtask

    task automatic idle();
        step(0, 0, none, 4'h0, none);
    endtask

    task automatic do_reset();
        step(1, 0, none, 4'h0, none);
    endtask

    ent_t        head;
    ent_t        re;
    ent_t        rc;
    logic [3:0]  rwe;
    int          k;

    initial begin
        none              = '0;
        reset             = 1'b1;
        exp_valid         = 1'b0;
        exp_pc            = '0;
        exp_wnum          = '0;
        exp_wdata         = '0;
        debug_wb_pc       = '0;
        debug_wb_rf_we    = '0;
        debug_wb_rf_wnum  = '0;
        debug_wb_rf_wdata = '0;

        do_reset();
        idle();

        // Two in-order matching commits
        push(mk(32'h1c000000, 5'd1, 32'h5));
        push(mk(32'h1c000004, 5'd2, 32'h7));
        commit(4'hf, mk(32'h1c000000, 5'd1, 32'h5));
        commit(4'hf, mk(32'h1c000004, 5'd2, 32'h7));
        idle();

        // Data mismatch, then a later matching commit is ignored
        do_reset();
        push(mk(32'h1c000000, 5'd3, 32'h10));
        commit(4'hf, mk(32'h1c000000, 5'd3, 32'h11));
        push(mk(32'h1c000010, 5'd6, 32'h22));
        commit(4'hf, mk(32'h1c000010, 5'd6, 32'h22));
        idle();

        // Underflow
        do_reset();
        commit(4'hf, mk(32'h1c000008, 5'd4, 32'h1));
        idle();

        // Fill to full (17th refused), free one slot, then fill/drain repeatedly for wrap
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) push(mk(32'h1c001000 + 32'(i * 4), 5'(i % 31 + 1), 32'(i * 3)));
        head = mq[0];
        commit(4'h1, head);
        idle();
        for (int rnd = 0; rnd < 3; rnd++) begin
            while (mq.size() < DEPTH) push(mk($urandom, 5'($urandom_range(1, 31)), $urandom));
            push(mk($urandom, 5'd9, $urandom));
            while (mq.size() > 0) begin
                head = mq[0];
                commit(4'($urandom_range(1, 15)), head);
            end
        end
        idle();

        // r0 writes and we=0 cycles are ignored; a single-lane enable still commits
        do_reset();
        push(mk(32'h1c000020, 5'd5, 32'd9));
        commit(4'hf, mk(32'h1c000020, 5'd0, 32'd9));
        commit(4'h0, mk(32'h1c000020, 5'd5, 32'd9));
        idle();
        commit(4'b0001, mk(32'h1c000020, 5'd5, 32'd9));
        idle();

        // Reset discards queued entries and error state
        do_reset();
        for (int i = 0; i < 4; i++) push(mk(32'h1c002000 + 32'(i * 4), 5'd7, 32'(i)));
        commit(4'hf, mk(32'h1c002000, 5'd7, 32'hdead));
        idle();
        do_reset();
        idle();

        // Simultaneous push with commit on an empty FIFO still underflows
        do_reset();
        step(0, 1, mk(32'h1c003000, 5'd8, 32'h1), 4'hf, mk(32'h1c003000, 5'd8, 32'h1));
        idle();

        // Randomized traffic with occasional resets
        do_reset();
        for (k = 0; k < 3000; k++) begin
            re = mk(32'h1c000000 | ($urandom & 32'hff), 5'($urandom_range(1, 31)), $urandom & 32'h3);
            rwe = ($urandom_range(0, 99) < 50) ? 4'($urandom_range(1, 15)) : 4'h0;
            if (mq.size() > 0 && $urandom_range(0, 99) < 92) begin
                rc = mq[0];
            end else begin
                rc = mk(32'h1c000000 | ($urandom & 32'hff), 5'($urandom_range(0, 31)), $urandom & 32'h3);
            end
            if ($urandom_range(0, 99) < 5) rc.wnum = 5'd0;
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 55), re, rwe, rc);
        end

        idle();
        idle();
        for (int t = 0; t < 20 && sb.size() > 0; t++) @(posedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trace_checker.md
Name: trace_checker

Overview:
- Receiving end of the core's write-back trace debug interface: `debug_wb_pc`, `debug_wb_rf_we`, `debug_wb_rf_wnum`, `debug_wb_rf_wdata`.
- A golden-trace source pushes expected commits into an internal FIFO over a valid/ready handshake.
- Each register-file commit from the core is compared against the FIFO head. Mismatches and underflows are reported with sticky, registered error fields.
- Sits beside mycpu_top in the SoC/test top. The core is not modified.

Parameters:
- FIFO_DEPTH, 16, expected-entry FIFO depth; power of two, 2..256.
- PTR_W, 4, log2(FIFO_DEPTH).

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `exp_valid`  in  1  expected entry offered
- `exp_ready`  out  1  FIFO can accept the entry
- `exp_pc`  in  32  expected commit PC
- `exp_wnum`  in  5  expected destination register
- `exp_wdata`  in  32  expected write data
- `debug_wb_pc`  in  32  core commit PC
- `debug_wb_rf_we`  in  4  core RF write enable (byte lanes)
- `debug_wb_rf_wnum`  in  5  core destination register
- `debug_wb_rf_wdata`  in  32  core write data
- `fifo_count`  out  PTR_W+1  current FIFO occupancy
- `pass_cnt`  out  32  number of matched commits
- `err`  out  1  sticky: mismatch or underflow occurred
- `underflow`  out  1  sticky: commit arrived with FIFO empty
- `err_pc`  out  32  core PC of the first failing commit
- `err_wnum`  out  5  core wnum of the first failing commit
- `err_got_wdata`  out  32  core wdata of the first failing commit
- `err_exp_wdata`  out  32  head wdata at failure (0 on underflow)

Behaviour:
- Reset (clk = reset, synchronous, active-high):
  - FIFO emptied; `fifo_count`=0.
  - `pass_cnt`=0; `err`=0; `underflow`=0.
  - All `err_*` fields = 0.
  - FSM = RUN.
  - `exp_ready`=0 while `reset` is high.
  - Reset mid-run discards all FIFO contents and error state.
- Push:
  - `exp_ready` = !reset && (`fifo_count` != FIFO_DEPTH).
  - An entry is written when `exp_valid` && `exp_ready` at the clock edge.
  - When full, a push is refused even if a pop occurs in the same cycle.
- commit = (`debug_wb_rf_we` != 0) && (`debug_wb_rf_wnum` != 0).
  - Any nonzero lane counts as a commit.
  - Writes to r0 and cycles with `we`=0 are ignored entirely.
- Comparison:
  - Uses FIFO contents as they stand before this edge.
  - A same-cycle push is not visible to a same-cycle commit.
  - Match = pc, wnum and wdata all equal the head entry.
- FSM states RUN and ERROR:
  - RUN, commit, FIFO empty: `underflow`<=1, `err`<=1, capture core pc/wnum/wdata, `err_exp_wdata`<=0, go ERROR.
  - RUN, commit, match: pop head, `pass_cnt`++, stay RUN.
  - RUN, commit, mismatch: pop head, `err`<=1, capture core pc/wnum/wdata and head wdata, go ERROR.
  - ERROR: terminal until reset. Commits are ignored: no pop, no count, and `err_*` frozen to the first failure. Pushes continue while not full.
- Simultaneous push and pop: `fifo_count` unchanged, head advances, tail advances.
- Pointers are PTR_W bits and wrap modulo FIFO_DEPTH. Full/empty are decided by `fifo_count`.
- `pass_cnt` wraps 0xFFFFFFFF -> 0 with no flag.
- Latency: all outputs are registered. Results of a commit at edge N are visible after edge N.

Test Plan:
1. Push (0x1c000000, r1, 0x5), (0x1c000004, r2, 0x7); core commits both in order -> `pass_cnt`=2, `err`=0, `fifo_count`=0.
2. Push (0x1c000000, r3, 0x10); core commits r3 = 0x11 -> `err`=1, `underflow`=0, `err_pc`=0x1c000000, `err_wnum`=3, `err_got_wdata`=0x11, `err_exp_wdata`=0x10. A later matching commit leaves `pass_cnt`=0.
3. Empty FIFO; core commits (0x1c000008, r4, 0x1) -> `err`=1, `underflow`=1, `err_exp_wdata`=0.
4. Push 16 entries with `exp_valid` held -> `exp_ready`=0, `fifo_count`=16. A 17th push is refused. One matching commit -> `exp_ready`=1 next cycle. Fill/drain three more times to exercise pointer wrap; expect `pass_cnt` to total the matched commits and `err`=0.
5. Push (pc, r5, 9); then `rf_we`=0xF with wnum=0, and `rf_we`=0 with wnum=5 -> no pop, `pass_cnt`=0, `fifo_count`=1. A partial `rf_we`=4'b0001 matching commit -> `pass_cnt`=1.
6. Create an error with 3 entries queued, then assert `reset` for 1 cycle -> `err`=0, `underflow`=0, `fifo_count`=0, `pass_cnt`=0, `exp_ready`=0 during reset and 1 after.
